// File: rtl/cpu_pkg.sv
// Shared definitions for the boot-time instruction-memory loader.
//   loader_state_t : loader FSM states
//   INSTR_W        : instruction word width in bits
//   BYTES_PER_WORD : bytes per instruction word on the byte stream
//   count_ok()     : legality test for the 16-bit word count in a frame header
package cpu_pkg;

    localparam int INSTR_W        = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        RUN,
        ERR
    } loader_state_t;

    // A frame must carry at least one word and no more than the memory holds.
    function automatic logic count_ok(input logic [15:0] n, input int max_words);
        return (n != 16'd0) && (int'(n) <= max_words);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
//   rx_valid/rx_data/rx_ready : incoming byte stream, valid/ready handshake
//   imem_we/imem_addr/imem_wdata : registered one-cycle word write
// master : the loader (consumes bytes, drives the memory port)
// slave  : the byte source and instruction memory
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/imem_loader_byte_to_word_packer.sv
// Assembles big-endian instruction words from a byte stream.
//   clk, rst   : clock, synchronous active-high reset
//   clear      : restart assembly at byte 0 (new frame)
//   byte_en    : a byte is being consumed this cycle
//   byte_in    : the byte
//   word       : completed word, valid together with word_valid
//   word_valid : combinational pulse on the cycle the 4th byte is consumed
module byte_to_word_packer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_en,
    input  logic [7:0]         byte_in,
    output logic [INSTR_W-1:0] word,
    output logic               word_valid
);

    logic [INSTR_W-1:0] shift_reg;
    logic [1:0]         byte_idx_reg;

    // The finished word includes the byte arriving now, so the caller can
    // register it on the same edge that consumes the last byte.
    assign word       = {shift_reg[INSTR_W-9:0], byte_in};
    assign word_valid = byte_en && (byte_idx_reg == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            shift_reg    <= '0;
            byte_idx_reg <= '0;
        end else if (byte_en) begin
            shift_reg    <= word;
            byte_idx_reg <= byte_idx_reg + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time program loader in front of the CPU instruction memory.
// Frame: count_hi, count_lo, 4*N data bytes (MSB first), XOR checksum of data.
//   clk, rst : clock, synchronous active-high reset
//   bus      : byte stream in, instruction-memory write port out
//   start    : one-cycle pulse beginning a load (ignored while busy)
//   cpu_rst  : CPU reset, released only in RUN after a verified load
//   busy     : frame in progress
//   done     : load verified, CPU running
//   err      : bad count or checksum
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.master bus,
    input  logic          start,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // One extra bit so N == MAX_WORDS never wraps the index.
    localparam int WIDX_W = ADDR_W + 1;

    loader_state_t      state_reg, state_next;
    logic [15:0]        count_reg;
    logic [WIDX_W-1:0]  word_idx_reg;
    logic [7:0]         csum_reg;
    logic               imem_we_reg;
    logic [ADDR_W-1:0]  imem_addr_reg;
    logic [INSTR_W-1:0] imem_wdata_reg;

    logic               accept;
    logic               start_ok;
    logic               data_en;
    logic               last_word;
    logic [INSTR_W-1:0] packed_word;
    logic               word_valid;

    assign accept   = bus.rx_valid && bus.rx_ready;
    assign start_ok = start && (state_reg inside {IDLE, RUN, ERR});
    assign data_en  = accept && (state_reg == DATA);

    // Word being completed now is the final one of the frame.
    assign last_word = (16'(word_idx_reg) + 16'd1) == count_reg;

    byte_to_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (start_ok),
        .byte_en    (data_en),
        .byte_in    (bus.rx_data),
        .word       (packed_word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bus.rx_ready = 1'b0;
        cpu_rst      = 1'b1;
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) state_next = LEN_HI;
            end
            LEN_HI: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (accept) state_next = LEN_LO;
            end
            LEN_LO: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (accept) begin
                    state_next = count_ok({count_reg[15:8], bus.rx_data}, MAX_WORDS)
                               ? DATA : ERR;
                end
            end
            DATA: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (word_valid && last_word) state_next = CSUM;
            end
            CSUM: begin
                bus.rx_ready = 1'b1;
                busy         = 1'b1;
                if (accept) state_next = (bus.rx_data == csum_reg) ? RUN : ERR;
            end
            RUN: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (start) state_next = LEN_HI;
            end
            ERR: begin
                err = 1'b1;
                if (start) state_next = LEN_HI;
            end
            default: state_next = IDLE;
        endcase
    end

    // Write registers are separate from the packer, so the next word's bytes
    // keep flowing while the previous word is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg      <= '0;
            word_idx_reg   <= '0;
            csum_reg       <= '0;
            imem_we_reg    <= 1'b0;
            imem_addr_reg  <= '0;
            imem_wdata_reg <= '0;
        end else begin
            imem_we_reg <= word_valid;
            if (word_valid) begin
                imem_addr_reg  <= word_idx_reg[ADDR_W-1:0];
                imem_wdata_reg <= packed_word;
                word_idx_reg   <= word_idx_reg + 1'b1;
            end
            if (start_ok) begin
                word_idx_reg <= '0;
                csum_reg     <= '0;
            end
            if (accept && state_reg == LEN_HI) count_reg[15:8] <= bus.rx_data;
            if (accept && state_reg == LEN_LO) count_reg[7:0]  <= bus.rx_data;
            if (data_en) csum_reg <= csum_reg ^ bus.rx_data;
        end
    end

    assign bus.imem_we    = imem_we_reg;
    assign bus.imem_addr  = imem_addr_reg;
    assign bus.imem_wdata = imem_wdata_reg;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic cpu_rst, busy, done, err;

    imem_loader_if #(.ADDR_W(8)) bus ();

    imem_loader #(.ADDR_W(8), .MAX_WORDS(256)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .start   (start),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Every observed memory write, in order: {addr, data}.
    logic [39:0] wq[$];
    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) wq.push_back({bus.imem_addr, bus.imem_wdata});
    end

    logic [31:0] tb_mem  [256];   // memory as seen through observed writes
    logic [31:0] ref_mem [256];   // memory the frames should have produced
    logic [31:0] words[$];        // payload of the next frame

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int g;
        int t;
        g = $urandom_range(max_gap, 0);
        repeat (g) begin @(posedge clk); #1; end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        t = 0;
        @(negedge clk);
        while (bus.rx_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) chk("hs_timeout", 64'(t), 64'd0);
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    task automatic mem_compare(input int base);
        int diffs;
        for (int i = base; i < wq.size(); i++) tb_mem[wq[i][39:32]] = wq[i][31:0];
        diffs = 0;
        for (int a = 0; a < 256; a++) if (tb_mem[a] !== ref_mem[a]) diffs++;
        chk("mem_contents", 64'(diffs), 64'd0);
    endtask

    // One complete frame; words[] holds the payload when the count is legal.
    task automatic do_load(input logic [15:0] n, input bit bad_csum, input int max_gap);
        int base;
        int bad_entries;
        logic [7:0] cs;
        base = wq.size();
        cs   = 8'h00;
        pulse_start();
        chk("start_busy", {63'd0, busy}, 64'd1);
        chk("start_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("start_done", {63'd0, done}, 64'd0);
        chk("start_ready", {63'd0, bus.rx_ready}, 64'd1);
        send_byte(n[15:8], max_gap);
        send_byte(n[7:0], max_gap);
        if (n == 16'd0 || n > 16'd256) begin
            chk("badcnt_err", {63'd0, err}, 64'd1);
            chk("badcnt_ready", {63'd0, bus.rx_ready}, 64'd0);
            chk("badcnt_busy", {63'd0, busy}, 64'd0);
            repeat (3) begin @(posedge clk); #1; end
            chk("badcnt_writes", 64'(wq.size() - base), 64'd0);
            return;
        end
        foreach (words[i]) begin
            for (int k = 3; k >= 0; k--) begin
                cs = cs ^ words[i][8*k +: 8];
                send_byte(words[i][8*k +: 8], max_gap);
            end
        end
        chk("pre_csum_cpu", {63'd0, cpu_rst}, 64'd1);
        chk("pre_csum_busy", {63'd0, busy}, 64'd1);
        send_byte(bad_csum ? (cs ^ 8'h01) : cs, max_gap);
        chk("end_cpu_rst", {63'd0, cpu_rst}, {63'd0, bad_csum});
        chk("end_done", {63'd0, done}, {63'd0, !bad_csum});
        chk("end_err", {63'd0, err}, {63'd0, bad_csum});
        chk("end_busy", {63'd0, busy}, 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("wr_count", 64'(wq.size() - base), 64'(n));
        bad_entries = 0;
        for (int i = 0; i < int'(n) && base + i < wq.size(); i++) begin
            if (wq[base + i] !== {i[7:0], words[i]}) bad_entries++;
        end
        chk("wr_order", 64'(bad_entries), 64'd0);
        foreach (words[i]) ref_mem[i] = words[i];
        mem_compare(base);
    endtask

    initial begin
        int base;
        rst          = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        for (int a = 0; a < 256; a++) begin
            tb_mem[a]  = 32'h0;
            ref_mem[a] = 32'h0;
        end
        repeat (3) begin @(posedge clk); #1; end

        // Reset state
        chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_ready", {63'd0, bus.rx_ready}, 64'd0);
        chk("rst_we", {63'd0, bus.imem_we}, 64'd0);
        chk("rst_addr", 64'(bus.imem_addr), 64'd0);
        chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);

        // start coinciding with rst: reset wins
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_vs_start", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        // Normal load
        words = '{32'h20100200, 32'h2011000C};
        do_load(16'd2, 1'b0, 0);

        // Bad checksum: words still land, CPU stays in reset
        do_load(16'd2, 1'b1, 0);

        // Bad counts
        do_load(16'h0000, 1'b0, 0);
        do_load(16'h0101, 1'b0, 0);

        // Backpressure gaps
        for (int r = 0; r < 3; r++) begin
            words = '{32'h20100200, 32'h2011000C};
            do_load(16'd2, 1'b0, 3);
        end
        fill_random(5);
        do_load(16'd5, 1'b0, 3);

        // Reset mid-load after 6 data bytes
        fill_random(2);
        base = wq.size();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'd27, 0);
        for (int k = 3; k >= 0; k--) send_byte(words[0][8*k +: 8], 1);
        send_byte(words[1][31:24], 1);
        send_byte(words[1][23:16], 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_cpu_rst", {63'd0, cpu_rst}, 64'd1);
        chk("mid_busy", {63'd0, busy}, 64'd0);
        chk("mid_done", {63'd0, done}, 64'd0);
        chk("mid_err", {63'd0, err}, 64'd0);
        chk("mid_ready", {63'd0, bus.rx_ready}, 64'd0);
        chk("mid_addr", 64'(bus.imem_addr), 64'd0);
        repeat (2) begin @(posedge clk); #1; end
        chk("mid_writes", 64'(wq.size() - base), 64'd1);
        ref_mem[0] = words[0];
        mem_compare(base);

        // Full 27-word load after the abort
        fill_random(27);
        do_load(16'd27, 1'b0, 1);

        // Restart from RUN with a 1-word frame: only addr0 changes
        chk("run_done", {63'd0, done}, 64'd1);
        fill_random(1);
        do_load(16'd1, 1'b0, 0);

        // Largest legal frame
        fill_random(256);
        do_load(16'd256, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
